sensor_vote_alarm: RTL

SENSOR_VOTE_ALARM -- requirements
Module: sensor_vote_alarm

---
 rtl/sensor_vote_alarm.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sensor_vote_alarm.sv
// Purpose: debounce up to four sensor channels, count how many are asserted and raise
//          an alarm (steady, then blinking) when the count reaches THRESH while armed.
// Latency: raw channel change appears on io_out[i] DB_CYCLES+1 edges after capture;
//          vote count is combinational from the debounced state; alarm follows one edge later.
// Backpressure: none; a free-running sampled monitor with no handshake.
//
// Ports:
//   io_in[0]    clk    rising-edge clock
//   io_in[1]    rst_n  synchronous active-low reset
//   io_in[5:2]  raw sensor channels (ch[i] = io_in[2+i])
//   io_in[6]    arm    monitor enable (level)
//   io_in[7]    clr    alarm acknowledge (level)
//   io_out[3:0] debounced channel states (bits >= N_CH tied 0)
//   io_out[6:4] vote count
//   io_out[7]   alarm
module sensor_vote_alarm #(
  parameter int N_CH       = 4,
  parameter int DB_CYCLES  = 8,
  parameter int THRESH     = 3,
  parameter int HOLD       = 16,
  parameter int BLINK_LOG2 = 2
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_ALERT   = 2'd2;
  localparam logic [1:0] ST_LATCHED = 2'd3;

  localparam int BW = BLINK_LOG2 + 1;

  logic clk;
  logic rst_n;
  assign clk   = io_in[0];
  assign rst_n = io_in[1];

  // Two-flop synchronizer for {clr, arm, ch[3:0]}.
  logic [5:0] sync_q1;
  logic [5:0] sync_q2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= io_in[7:2];
      sync_q2 <= sync_q1;
    end
  end

  logic [3:0] ch_s;
  logic       arm_s;
  logic       clr_s;
  assign ch_s  = sync_q2[3:0];
  assign arm_s = sync_q2[4];
  assign clr_s = sync_q2[5];

  // Debounce: the counter tracks consecutive mismatch cycles; the commit clears it,
  // so an input change landing on the commit edge starts a fresh count.
  logic [3:0] db_q;
  logic [7:0] db_cnt_q [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i >= N_CH) begin
          db_q[i]     <= 1'b0;
          db_cnt_q[i] <= '0;
        end else if (ch_s[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == 8'(DB_CYCLES - 1)) begin
          db_q[i]     <= ch_s[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  logic [2:0] vote;
  always_comb begin
    vote = '0;
    for (int i = 0; i < 4; i++) vote = vote + {2'b00, db_q[i]};
  end

  logic trig;
  assign trig = (vote >= 3'(THRESH));

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [7:0]    hold_q;
  logic [BW-1:0] blink_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (arm_s) state_d = ST_ARMED;
      ST_ARMED:   if (!arm_s) state_d = ST_IDLE;
                  else if (trig) state_d = ST_ALERT;
      ST_ALERT:   if (hold_q == 8'd0 && !trig) state_d = ST_LATCHED;
      ST_LATCHED: if (clr_s) state_d = arm_s ? ST_ARMED : ST_IDLE;
                  else if (trig) state_d = ST_ALERT;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      // Load on any entry into ALERT (including re-trigger), then count down to 0 and stop.
      if (state_d == ST_ALERT && state_q != ST_ALERT) begin
        hold_q <= 8'(HOLD - 1);
      end else if (state_q == ST_ALERT && hold_q != 8'd0) begin
        hold_q <= hold_q - 8'd1;
      end
      // Blink phase runs only while staying in LATCHED; zero on entry gives alarm=1 first.
      if (state_q == ST_LATCHED && state_d == ST_LATCHED) begin
        blink_q <= blink_q + BW'(1);
      end else begin
        blink_q <= '0;
      end
    end
  end

  logic alarm;
  assign alarm = (state_q == ST_ALERT) ||
                 (state_q == ST_LATCHED && !blink_q[BLINK_LOG2]);

  // Held at zero while reset is asserted, even before the first reset edge.
  assign io_out = rst_n ? {alarm, vote, db_q} : 8'h00;

endmodule
